// File: rtl/dds_sequencer_pkg.sv
// Shared configuration for the DDS table-load / phase sequencer.
// Table geometry defaults, the state encoding and phase-range helpers.
package dds_sequencer_pkg;

  localparam int unsigned DATA_LEN_DEF  = 11;
  localparam int unsigned ROWS_BASE_2   = 6;
  localparam int unsigned MEMORY_HEIGHT = 64;
  localparam int unsigned PHASE_W       = 9;
  localparam logic [PHASE_W-1:0] MAX_DEG = 9'd359;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_PHASE  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  function automatic logic deg_ok(input logic [PHASE_W-1:0] deg);
    return deg <= MAX_DEG;
  endfunction

endpackage

// File: rtl/dds_sequencer_settle_timer.sv
// Loadable down-counter that holds the sequencer in SETTLE after a re-phase.
// done_c is high whenever the count has reached zero.
module dds_sequencer_settle_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/dds_sequencer.sv
// Owns the DDS table-write and set_phase ports: streams one quarter-sine table
// in from a valid/ready source, then re-phases, and serialises host phase requests.
module dds_sequencer
  import dds_sequencer_pkg::*;
#(
  parameter int unsigned DATA_LEN   = DATA_LEN_DEF,
  parameter int unsigned ADDR_W     = ROWS_BASE_2,
  parameter int unsigned DEPTH      = MEMORY_HEIGHT,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                src_clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                ld_valid,
  input  logic [DATA_LEN-1:0] ld_data,
  output logic                ld_ready,
  input  logic                ph_req,
  input  logic [8:0]          ph_deg,
  output logic                ph_ack,
  output logic                ph_err,
  output logic                busy,
  output logic                load_done,
  output logic                dds_we,
  output logic [ADDR_W-1:0]   dds_addr_wr,
  output logic [DATA_LEN-1:0] dds_data_wr,
  output logic                dds_set_phase,
  output logic [8:0]          dds_phase
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                last_q, last_d;
  logic                ld_ready_q, ld_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic                load_done_q, load_done_d;
  logic                set_phase_q, set_phase_d;
  logic [8:0]          phase_q, phase_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [8:0]          cur_q, cur_d;
  logic                pend_v_q, pend_v_d;
  logic [8:0]          pend_deg_q, pend_deg_d;

  logic req_ok_c, req_used_c, accept_c;
  logic tmr_load_c, tmr_dec_c, tmr_done_c;

  dds_sequencer_settle_timer #(.CNT_W(CNT_W)) u_settle (
    .clk      (src_clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (CNT_W'(SETTLE_CYC - 1)),
    .dec      (tmr_dec_c),
    .done_c   (tmr_done_c)
  );

  // Next-state and registered-output decode; outputs line up with state_d.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    ld_ready_d  = ld_ready_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    load_done_d = 1'b0;
    set_phase_d = 1'b0;
    phase_d     = phase_q;
    ack_d       = 1'b0;
    cur_d       = cur_q;
    pend_v_d    = pend_v_q;
    pend_deg_d  = pend_deg_q;
    tmr_load_c  = 1'b0;
    tmr_dec_c   = 1'b0;
    req_used_c  = 1'b0;
    req_ok_c    = ph_req && deg_ok(ph_deg);
    err_d       = ph_req && !deg_ok(ph_deg);
    accept_c    = (state_q == ST_LOAD) && ld_valid && ld_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          idx_d      = '0;
          last_d     = 1'b0;
          ld_ready_d = 1'b1;
        end else if (pend_v_q) begin
          state_d     = ST_PHASE;
          set_phase_d = 1'b1;
          phase_d     = pend_deg_q;
          cur_d       = pend_deg_q;
          ack_d       = 1'b1;
          pend_v_d    = 1'b0;
        end else if (req_ok_c) begin
          state_d     = ST_PHASE;
          set_phase_d = 1'b1;
          phase_d     = ph_deg;
          cur_d       = ph_deg;
          ack_d       = 1'b1;
          req_used_c  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          we_d   = 1'b1;
          addr_d = idx_q;
          data_d = ld_data;
          if (idx_q == ADDR_W'(DEPTH - 1)) begin
            last_d      = 1'b1;
            ld_ready_d  = 1'b0;
            load_done_d = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else if (last_q) begin
          // Re-phase one cycle after the final write so we and set_phase never overlap.
          state_d     = ST_PHASE;
          set_phase_d = 1'b1;
          if (pend_v_q) begin
            phase_d  = pend_deg_q;
            cur_d    = pend_deg_q;
            ack_d    = 1'b1;
            pend_v_d = 1'b0;
          end else begin
            phase_d = cur_q;
          end
        end
      end
      ST_PHASE: begin
        state_d    = ST_SETTLE;
        tmr_load_c = 1'b1;
      end
      ST_SETTLE: begin
        if (tmr_done_c) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any valid request not issued this cycle waits; the latest one wins.
    if (req_ok_c && !req_used_c) begin
      pend_v_d   = 1'b1;
      pend_deg_d = ph_deg;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= 1'b0;
      ld_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      load_done_q <= 1'b0;
      set_phase_q <= 1'b0;
      phase_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cur_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_deg_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      ld_ready_q  <= ld_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      load_done_q <= load_done_d;
      set_phase_q <= set_phase_d;
      phase_q     <= phase_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cur_q       <= cur_d;
      pend_v_q    <= pend_v_d;
      pend_deg_q  <= pend_deg_d;
    end
  end

  assign ld_ready      = ld_ready_q;
  assign ph_ack        = ack_q;
  assign ph_err        = err_q;
  assign busy          = busy_q;
  assign load_done     = load_done_q;
  assign dds_we        = we_q;
  assign dds_addr_wr   = addr_q;
  assign dds_data_wr   = data_q;
  assign dds_set_phase = set_phase_q;
  assign dds_phase     = phase_q;

endmodule

// File: tb/tb_dds_sequencer.sv
// Scoreboard bench for dds_sequencer: stimulus queues expected table writes and
// re-phase commands; a negedge monitor pops and compares whenever the DUT emits one.
module tb_dds_sequencer;

  localparam int DL     = 11;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 16;

  logic          src_clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DL-1:0] ld_data = '0;
  logic          ph_req = 1'b0;
  logic [8:0]    ph_deg = '0;
  logic          ld_ready, ph_ack, ph_err, busy, load_done;
  logic          dds_we, dds_set_phase;
  logic [AW-1:0] dds_addr_wr;
  logic [DL-1:0] dds_data_wr;
  logic [8:0]    dds_phase;

  dds_sequencer #(.DATA_LEN(DL), .ADDR_W(AW), .DEPTH(DEPTH), .SETTLE_CYC(SETTLE)) dut (
    .src_clk(src_clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ph_req(ph_req), .ph_deg(ph_deg),
    .ph_ack(ph_ack), .ph_err(ph_err), .busy(busy), .load_done(load_done),
    .dds_we(dds_we), .dds_addr_wr(dds_addr_wr), .dds_data_wr(dds_data_wr),
    .dds_set_phase(dds_set_phase), .dds_phase(dds_phase)
  );

  always #5 src_clk = ~src_clk;

  typedef struct { int addr; int data; bit done; } wr_t;
  typedef struct { int deg; bit ack; } ph_t;

  wr_t wq[$];
  ph_t pq[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  err_total = 0;
  int  err_seen = 0;
  int  req_tab[DEPTH];
  bit  sp_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DL-1:0] word(input int i, input int salt);
    logic [6:0] amp;
    logic [3:0] hold;
    amp  = 7'(i * 5 + salt * 17);
    hold = 4'(i + salt);
    return {amp, hold};
  endfunction

  // Monitor: every DUT write / re-phase is matched against the scoreboard.
  always @(negedge src_clk) begin
    if (!rst) begin
      if (dds_we) begin
        if (wq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wr_unexpected: got addr %0d, expected no write", dds_addr_wr);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", int'(dds_addr_wr), e.addr);
          chk("wr_data", int'(dds_data_wr), e.data);
          chk("wr_load_done", int'(load_done), int'(e.done));
        end
      end else if (load_done) begin
        chk("load_done_without_we", int'(dds_we), 1);
      end
      if (dds_set_phase) begin
        chk("sp_with_we", int'(dds_we), 0);
        chk("sp_consecutive", int'(sp_prev), 0);
        if (pq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sp_unexpected: got phase %0d, expected no set_phase", dds_phase);
        end else begin
          ph_t p;
          p = pq.pop_front();
          chk("sp_phase", int'(dds_phase), p.deg);
          chk("sp_ack", int'(ph_ack), int'(p.ack));
        end
      end else if (ph_ack) begin
        chk("ack_without_sp", int'(dds_set_phase), 1);
      end
      if (ph_err) err_seen++;
    end
    sp_prev = dds_set_phase;
  end

  task automatic clr_reqs();
    for (int i = 0; i < DEPTH; i++) req_tab[i] = -1;
  endtask

  // Streams n_words table words; req_tab[i] >= 0 pulses ph_req alongside word i.
  task automatic do_load(input bit gaps, input int n_words, input int salt);
    load_start = 1'b1;
    @(posedge src_clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < n_words; i++) begin
      int w;
      wq.push_back('{addr: i, data: int'(word(i, salt)), done: (i == DEPTH - 1)});
      ld_valid = 1'b1;
      ld_data  = word(i, salt);
      ph_req   = (req_tab[i] >= 0);
      ph_deg   = (req_tab[i] >= 0) ? 9'(req_tab[i]) : 9'd0;
      w = 0;
      while (!ld_ready && w < 50) begin
        @(posedge src_clk); #1;
        w++;
      end
      if (!ld_ready) chk("ld_ready_timeout", int'(ld_ready), 1);
      @(posedge src_clk); #1;
      ph_req = 1'b0;
      if (gaps) begin
        ld_valid = 1'b0;
        @(posedge src_clk); #1;
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge src_clk); #1;
      n++;
    end
    if (busy) chk("busy_timeout", int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr_reqs();
    repeat (3) @(posedge src_clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ld_ready", int'(ld_ready), 0);
    chk("rst_we", int'(dds_we), 0);
    chk("rst_set_phase", int'(dds_set_phase), 0);
    chk("rst_phase", int'(dds_phase), 0);
    rst = 1'b0;
    @(posedge src_clk); #1;

    // Back-to-back full load, re-phase to reset phase 0 without ack.
    pq.push_back('{deg: 0, ack: 1'b0});
    do_load(1'b0, DEPTH, 1);
    wait_idle(n);
    chk("load_busy_tail", n, SETTLE + 2);

    // Host phase request while idle.
    pq.push_back('{deg: 90, ack: 1'b1});
    ph_req = 1'b1; ph_deg = 9'd90;
    @(posedge src_clk); #1;
    ph_req = 1'b0;
    chk("req90_set_phase", int'(dds_set_phase), 1);
    chk("req90_ack", int'(ph_ack), 1);
    wait_idle(n);
    chk("req90_busy_len", n, SETTLE + 1);

    // Requests during load: 45 overwritten by 180; out-of-range 400 rejected.
    clr_reqs();
    req_tab[3] = 45; req_tab[8] = 180; req_tab[11] = 400;
    err_total++;
    pq.push_back('{deg: 180, ack: 1'b1});
    do_load(1'b0, DEPTH, 2);
    clr_reqs();
    wait_idle(n);
    chk("pend_load_busy_tail", n, SETTLE + 2);

    // Gapped load; post-load re-phase reuses current phase 180, no ack.
    pq.push_back('{deg: 180, ack: 1'b0});
    do_load(1'b1, DEPTH, 3);
    wait_idle(n);

    // Out-of-range request while idle.
    err_total++;
    ph_req = 1'b1; ph_deg = 9'd400;
    @(posedge src_clk); #1;
    ph_req = 1'b0;
    chk("err400_pulse", int'(ph_err), 1);
    chk("err400_no_sp", int'(dds_set_phase), 0);
    chk("err400_busy", int'(busy), 0);
    repeat (3) @(posedge src_clk);
    #1;
    chk("err400_idle_after", int'(busy), 0);

    // Reset while the write of word 4 is on the DDS port.
    do_load(1'b0, 5, 4);
    @(negedge src_clk); #1;
    chk("pre_rst_we", int'(dds_we), 1);
    rst = 1'b1;
    #1;
    chk("rst_we_drop", int'(dds_we), 0);
    chk("rst_busy_drop", int'(busy), 0);
    chk("rst_load_done", int'(load_done), 0);
    repeat (2) @(posedge src_clk);
    #1;
    rst = 1'b0;
    chk("rst_wq_drained", wq.size(), 0);

    // Fresh load restarts at address 0; phase back to 0.
    pq.push_back('{deg: 0, ack: 1'b0});
    do_load(1'b0, DEPTH, 5);
    wait_idle(n);
    chk("reload_busy_tail", n, SETTLE + 2);

    repeat (4) @(posedge src_clk);
    #1;
    chk("end_wq_empty", wq.size(), 0);
    chk("end_pq_empty", pq.size(), 0);
    chk("end_err_count", err_seen, err_total);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
